axi4_lite_slv_reg_bank: RTL and testbench

Parametrised AXI4-Lite slave that implements a bank of NUM_REGS memory-mapped registers. Each register is either read/write (driven to fabric) or read-only (sampled from fabric).
- Accepts AW and W independently, honours byte strobes, and returns SLVERR on out-of-range or read-only writes.
- Emits per-register write and read strobes for control/status logic.
- Sits between the AXI interconnect (slv_port side) and user control logic.

---
 rtl/axi4_lite_slv_reg_bank.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi4_lite_slv_reg_bank.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slv_reg_bank.sv
// AXI4-Lite slave exposing NUM_REGS memory-mapped registers.
// Each register is either read/write (held here, driven on reg_out) or
// read-only (value taken from reg_in at read time). Write address and write
// data are captured into independent holding registers and committed together
// once both are present and no write response is pending.
module axi4_lite_slv_reg_bank #(
    parameter int                          ADDR_BIT_WIDTH = 32,
    parameter int                          DATA_BIT_WIDTH = 32,
    parameter int                          NUM_REGS       = 16,
    parameter logic [ADDR_BIT_WIDTH-1:0]   BASE_ADDR      = '0,
    parameter logic [NUM_REGS-1:0]         RO_MASK        = '0,
    parameter logic [DATA_BIT_WIDTH-1:0]   RST_VAL        = '0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic [ADDR_BIT_WIDTH-1:0]            awaddr,
    input  logic [2:0]                           awprot,
    input  logic                                 awvalid,
    output logic                                 awready,

    input  logic [DATA_BIT_WIDTH-1:0]            wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0]          wstrb,
    input  logic                                 wvalid,
    output logic                                 wready,

    output logic [1:0]                           bresp,
    output logic                                 bvalid,
    input  logic                                 bready,

    input  logic [ADDR_BIT_WIDTH-1:0]            araddr,
    input  logic [2:0]                           arprot,
    input  logic                                 arvalid,
    output logic                                 arready,

    output logic [DATA_BIT_WIDTH-1:0]            rdata,
    output logic [1:0]                           rresp,
    output logic                                 rvalid,
    input  logic                                 rready,

    output logic [NUM_REGS*DATA_BIT_WIDTH-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0]   reg_in,
    output logic [NUM_REGS-1:0]                  wr_pulse,
    output logic [NUM_REGS-1:0]                  rd_pulse
);

    localparam int STRB_W   = DATA_BIT_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ADDR_BIT_WIDTH-1:0] NUM_REGS_A = ADDR_BIT_WIDTH'(NUM_REGS);

    // Word index relative to BASE_ADDR; addresses below the base wrap to a
    // huge index and therefore fall out of range naturally.
    function automatic logic [ADDR_BIT_WIDTH-1:0] word_of(input logic [ADDR_BIT_WIDTH-1:0] a);
        return (a - BASE_ADDR) >> ADDR_LSB;
    endfunction

    logic                          ready_en;

    logic                          aw_held;
    logic [ADDR_BIT_WIDTH-1:0]     aw_addr_q;
    logic                          w_held;
    logic [DATA_BIT_WIDTH-1:0]     w_data_q;
    logic [STRB_W-1:0]             w_strb_q;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          b_hs;
    logic                          r_hs;
    logic                          commit;

    logic [ADDR_BIT_WIDTH-1:0]     wr_word;
    logic [ADDR_BIT_WIDTH-1:0]     rd_word;
    logic                          wr_in_range;
    logic                          rd_in_range;
    logic [IDX_W-1:0]              wr_idx;
    logic [IDX_W-1:0]              rd_idx;
    logic [NUM_REGS-1:0]           wr_sel;
    logic [NUM_REGS-1:0]           rd_sel;
    logic                          ro_hit;
    logic                          wr_ok;
    logic [NUM_REGS-1:0]           wr_en;

    logic [NUM_REGS-1:0][DATA_BIT_WIDTH-1:0] rd_src;
    logic [DATA_BIT_WIDTH-1:0]     rd_mux;

    // Protection bits carry no meaning for this bank.
    logic                          unused_inputs;
    assign unused_inputs = ^{awprot, arprot};

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign ar_hs   = arvalid & arready;
    assign b_hs    = bvalid & bready;
    assign r_hs    = rvalid & rready;

    assign awready = ready_en & ~aw_held;
    assign wready  = ready_en & ~w_held;
    assign arready = ready_en & ~rvalid;

    // A write commits only when both halves are present and the previous
    // response has been taken, so a stalled B channel backs up AW/W.
    assign commit  = aw_held & w_held & ~bvalid;

    // Hold all ready outputs low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Write address holding register: filled on AW handshake, drained on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
        end else if (commit) begin
            aw_held   <= 1'b0;
        end else if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= awaddr;
        end
    end

    // Write data holding register: filled on W handshake, drained on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            w_held   <= 1'b0;
        end else if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
        end
    end

    assign wr_word     = word_of(aw_addr_q);
    assign rd_word     = word_of(araddr);
    assign wr_in_range = (wr_word < NUM_REGS_A);
    assign rd_in_range = (rd_word < NUM_REGS_A);
    assign wr_idx      = wr_word[IDX_W-1:0];
    assign rd_idx      = rd_word[IDX_W-1:0];

    // One-hot register selects for the pending write and the current read.
    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = wr_in_range & (wr_idx == IDX_W'(i));
            rd_sel[i] = rd_in_range & (rd_idx == IDX_W'(i));
        end
    end

    assign ro_hit = |(wr_sel & RO_MASK);
    assign wr_ok  = wr_in_range & ~ro_hit;
    assign wr_en  = {NUM_REGS{commit}} & wr_sel & ~RO_MASK;

    // Per-register storage: RW slots hold flops, RO slots are pass-through
    // from reg_in and show 0 on reg_out.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (RO_MASK[gi]) begin : g_ro
            assign reg_out[gi*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = '0;
            assign rd_src[gi] = reg_in[gi*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
        end else begin : g_rw
            logic [DATA_BIT_WIDTH-1:0] q;

            // Byte-enabled update on a committed write to this slot.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= RST_VAL;
                end else if (wr_en[gi]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            q[b*8 +: 8] <= w_data_q[b*8 +: 8];
                        end
                    end
                end
            end

            assign reg_out[gi*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] = q;
            assign rd_src[gi] = q;
        end
    end

    // Read data mux; out-of-range reads select nothing and return 0.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel[i]) begin
                rd_mux = rd_src[i];
            end
        end
    end

    // Write response: set by commit, held until the master takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid <= 1'b0;
            bresp  <= RESP_OKAY;
        end else if (commit) begin
            bvalid <= 1'b1;
            bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (b_hs) begin
            bvalid <= 1'b0;
        end
    end

    // Write strobe is high only in the cycle following the commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pulse <= '0;
        end else begin
            wr_pulse <= wr_en;
        end
    end

    // Read response: data sampled at the AR handshake, held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
            rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (r_hs) begin
            rvalid <= 1'b0;
        end
    end

    // Read strobe marks the accepted register for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pulse <= '0;
        end else begin
            rd_pulse <= ar_hs ? rd_sel : '0;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slv_reg_bank.sv
// Self-checking bench for axi4_lite_slv_reg_bank: directed scenarios plus a
// randomized sequence checked against a register-array reference model.
module tb_axi4_lite_slv_reg_bank;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam logic [NR-1:0] RO = 16'h0088;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [AW-1:0]      awaddr = '0;
    logic [2:0]         awprot = '0;
    logic               awvalid = 1'b0;
    logic               awready;
    logic [DW-1:0]      wdata = '0;
    logic [DW/8-1:0]    wstrb = '0;
    logic               wvalid = 1'b0;
    logic               wready;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               bready = 1'b0;
    logic [AW-1:0]      araddr = '0;
    logic [2:0]         arprot = '0;
    logic               arvalid = 1'b0;
    logic               arready;
    logic [DW-1:0]      rdata;
    logic [1:0]         rresp;
    logic               rvalid;
    logic               rready = 1'b0;
    logic [NR*DW-1:0]   reg_out;
    logic [NR*DW-1:0]   reg_in;
    logic [NR-1:0]      wr_pulse;
    logic [NR-1:0]      rd_pulse;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model  [NR];
    logic [DW-1:0] ro_val [NR];

    always #5 clk = ~clk;

    always_comb begin
        reg_in = '0;
        for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = ro_val[i];
    end

    axi4_lite_slv_reg_bank #(
        .ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW), .NUM_REGS(NR),
        .BASE_ADDR('0), .RO_MASK(RO), .RST_VAL('0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [NR*DW-1:0] exp_reg_out();
        logic [NR*DW-1:0] r;
        r = '0;
        for (int i = 0; i < NR; i++) r[i*DW +: DW] = RO[i] ? '0 : model[i];
        return r;
    endfunction

    task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] d,
                               input logic [3:0] s, output logic [1:0] resp,
                               output logic [NR-1:0] pulse);
        int unsigned idx;
        idx   = addr / 4;
        pulse = '0;
        if (idx >= NR || RO[idx]) begin
            resp = SLVERR;
        end else begin
            resp = OKAY;
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
            pulse[idx] = 1'b1;
        end
    endtask

    task automatic model_read(input logic [AW-1:0] addr, output logic [DW-1:0] d,
                              output logic [1:0] resp, output logic [NR-1:0] pulse);
        int unsigned idx;
        idx   = addr / 4;
        pulse = '0;
        if (idx >= NR) begin
            d = '0;
            resp = SLVERR;
        end else begin
            d = RO[idx] ? ro_val[idx] : model[idx];
            resp = OKAY;
            pulse[idx] = 1'b1;
        end
    endtask

    // ---------------- bus drivers ----------------
    // lat = edges from the last AW/W handshake edge until bvalid is seen.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic [NR-1:0] pulse,
                            output int lat, output bit to);
        bit aw_pend, w_pend, aw_fire, w_fire;
        int cyc;
        aw_pend = 1; w_pend = 1; cyc = 0; to = 0; lat = 0;
        resp = '0; pulse = '0;
        bready = 1'b1;
        awaddr = addr; awprot = 3'($urandom);
        wdata = data; wstrb = strb;
        while (aw_pend || w_pend) begin
            awvalid = aw_pend && (cyc >= aw_dly);
            wvalid  = w_pend && (cyc >= w_dly);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            tick();
            cyc++;
            if (aw_fire) aw_pend = 0;
            if (w_fire)  w_pend = 0;
            if (cyc > 60) begin to = 1; break; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        while (!to && !bvalid) begin
            tick();
            lat++;
            if (lat > 30) to = 1;
        end
        if (!to) begin
            resp  = bresp;
            pulse = wr_pulse;
            tick();
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] d,
                           output logic [1:0] resp, output logic [NR-1:0] pulse,
                           output int lat, output bit to);
        int n;
        n = 0; to = 0; lat = 0; d = '0; resp = '0; pulse = '0;
        rready = 1'b1;
        araddr = addr; arprot = 3'($urandom);
        arvalid = 1'b1;
        while (!arready) begin
            tick();
            n++;
            if (n > 30) begin to = 1; break; end
        end
        if (!to) tick();
        arvalid = 1'b0;
        while (!to && !rvalid) begin
            tick();
            lat++;
            if (lat > 30) to = 1;
        end
        if (!to) begin
            d     = rdata;
            resp  = rresp;
            pulse = rd_pulse;
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < NR; i++) begin
            model[i]  = '0;
            ro_val[i] = '0;
        end
        rst_n = 1'b0;
        repeat (5) tick();
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++; $display("FAIL reset_ready_in_reset: got %b required 000", {awready, wready, arready});
        end
        checks++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0 || rdata !== '0) begin
            errors++; $display("FAIL reset_resp: got bv=%b rv=%b bresp=%b rresp=%b rdata=%h required all 0",
                               bvalid, rvalid, bresp, rresp, rdata);
        end
        checks++;
        if (reg_out !== exp_reg_out() || wr_pulse !== '0 || rd_pulse !== '0) begin
            errors++; $display("FAIL reset_regs: got reg_out=%h wr=%h rd=%h required 0", reg_out, wr_pulse, rd_pulse);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++; $display("FAIL reset_ready_before_edge: got %b required 000", {awready, wready, arready});
        end
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++; $display("FAIL reset_ready_after_edge: got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_write_read();
        logic [1:0] r, er; logic [NR-1:0] p, ep; logic [DW-1:0] d, ed; int lat; bit to;
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, r, p, lat, to);
        model_write(32'h08, 32'hDEADBEEF, 4'hF, er, ep);
        checks++;
        if (to || r !== er || lat != 1) begin
            errors++; $display("FAIL wr_basic_resp: got to=%0d resp=%b lat=%0d required resp=%b lat=1", to, r, lat, er);
        end
        checks++;
        if (p !== ep || wr_pulse !== '0) begin
            errors++; $display("FAIL wr_basic_pulse: got %h then %h required %h then 0", p, wr_pulse, ep);
        end
        checks++;
        if (reg_out[2*DW +: DW] !== 32'hDEADBEEF || reg_out !== exp_reg_out()) begin
            errors++; $display("FAIL wr_basic_reg: got %h required %h", reg_out, exp_reg_out());
        end
        do_read(32'h08, d, r, p, lat, to);
        model_read(32'h08, ed, er, ep);
        checks++;
        if (to || d !== ed || r !== er || lat != 0) begin
            errors++; $display("FAIL rd_basic: got to=%0d data=%h resp=%b lat=%0d required data=%h resp=%b lat=0",
                               to, d, r, lat, ed, er);
        end
        checks++;
        if (p !== ep || rd_pulse !== '0) begin
            errors++; $display("FAIL rd_basic_pulse: got %h then %h required %h then 0", p, rd_pulse, ep);
        end
    endtask

    task automatic test_strobes();
        logic [1:0] r, er; logic [NR-1:0] p, ep; int lat; bit to;
        do_write(32'h08, 32'h11223344, 4'b0101, 3, 0, r, p, lat, to);
        model_write(32'h08, 32'h11223344, 4'b0101, er, ep);
        checks++;
        if (to || r !== er || lat != 1 || p !== ep) begin
            errors++; $display("FAIL strb_order: got to=%0d resp=%b lat=%0d pulse=%h required resp=%b lat=1 pulse=%h",
                               to, r, lat, p, er, ep);
        end
        checks++;
        if (reg_out[2*DW +: DW] !== 32'hDE22BE44 || reg_out !== exp_reg_out()) begin
            errors++; $display("FAIL strb_value: got %h required DE22BE44", reg_out[2*DW +: DW]);
        end
    endtask

    task automatic test_errors();
        logic [1:0] r, er; logic [NR-1:0] p, ep; logic [DW-1:0] d, ed; int lat; bit to;
        do_write(32'h40, 32'h55AA55AA, 4'hF, 0, 0, r, p, lat, to);
        model_write(32'h40, 32'h55AA55AA, 4'hF, er, ep);
        checks++;
        if (to || r !== SLVERR || r !== er || p !== ep || reg_out !== exp_reg_out()) begin
            errors++; $display("FAIL err_oor_write: got resp=%b pulse=%h required resp=10 pulse=0", r, p);
        end
        ro_val[3] = 32'hCAFE0003;
        do_write(32'h0C, 32'h12345678, 4'hF, 1, 0, r, p, lat, to);
        model_write(32'h0C, 32'h12345678, 4'hF, er, ep);
        checks++;
        if (to || r !== SLVERR || p !== '0 || reg_out !== exp_reg_out()) begin
            errors++; $display("FAIL err_ro_write: got resp=%b pulse=%h required resp=10 pulse=0", r, p);
        end
        do_read(32'h0C, d, r, p, lat, to);
        model_read(32'h0C, ed, er, ep);
        checks++;
        if (to || d !== 32'hCAFE0003 || r !== OKAY || p !== ep) begin
            errors++; $display("FAIL rd_ro: got data=%h resp=%b pulse=%h required data=%h resp=00 pulse=%h", d, r, p, ed, ep);
        end
        do_read(32'h40, d, r, p, lat, to);
        checks++;
        if (to || d !== '0 || r !== SLVERR || p !== '0) begin
            errors++; $display("FAIL rd_oor: got data=%h resp=%b pulse=%h required 0/10/0", d, r, p);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] er; logic [NR-1:0] ep; logic [DW-1:0] d1, d2; bit bad;
        d1 = $urandom(); d2 = $urandom();
        bready = 1'b0;
        awaddr = 32'h14; wdata = d1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        checks++;
        if (!(awready && wready)) begin
            errors++; $display("FAIL bp_idle_ready: got aw=%b w=%b required 1 1", awready, wready);
        end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        model_write(32'h14, d1, 4'hF, er, ep);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bvalid !== 1'b1 || bresp !== OKAY) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_b_hold: got bvalid/bresp unstable, required bvalid=1 bresp=00 for 10 cycles");
        end
        wdata = d2; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1) begin
            errors++; $display("FAIL bp_capture: got awready=%b wready=%b bvalid=%b required 0 0 1", awready, wready, bvalid);
        end
        repeat (3) tick();
        checks++;
        if (reg_out[5*DW +: DW] !== d1) begin
            errors++; $display("FAIL bp_no_commit: got %h required %h", reg_out[5*DW +: DW], d1);
        end
        bready = 1'b1;
        tick();
        checks++;
        if (bvalid !== 1'b0 || reg_out[5*DW +: DW] !== d1) begin
            errors++; $display("FAIL bp_b_taken: got bvalid=%b reg=%h required 0 %h", bvalid, reg_out[5*DW +: DW], d1);
        end
        tick();
        model_write(32'h14, d2, 4'hF, er, ep);
        checks++;
        if (bvalid !== 1'b1 || wr_pulse !== ep || reg_out !== exp_reg_out()) begin
            errors++; $display("FAIL bp_second_commit: got bvalid=%b pulse=%h reg=%h required 1 %h %h",
                               bvalid, wr_pulse, reg_out[5*DW +: DW], ep, d2);
        end
        tick();
        // read side
        rready = 1'b0;
        araddr = 32'h14; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rvalid !== 1'b1 || rdata !== model[5] || rresp !== OKAY || arready !== 1'b0) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_r_hold: got rvalid=%b rdata=%h arready=%b required 1 %h 0", rvalid, rdata, arready, model[5]);
        end
        rready = 1'b1;
        tick();
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            errors++; $display("FAIL bp_r_taken: got rvalid=%b arready=%b required 0 1", rvalid, arready);
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0] er; logic [NR-1:0] ep; logic [DW-1:0] old_v, nv;
        old_v = model[5]; nv = ~old_v;
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h14; wdata = nv; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h14; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        model_write(32'h14, nv, 4'hF, er, ep);
        checks++;
        if (rvalid !== 1'b1 || rdata !== old_v || bvalid !== 1'b1 || reg_out !== exp_reg_out()) begin
            errors++; $display("FAIL same_cycle: got rdata=%h bvalid=%b reg=%h required %h 1 %h",
                               rdata, bvalid, reg_out[5*DW +: DW], old_v, nv);
        end
        bready = 1'b1; rready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] r, er; logic [NR-1:0] p, ep; int lat; bit to;
        bready = 1'b1;
        awaddr = 32'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (2) tick();
        checks++;
        if (bvalid !== 1'b0 || reg_out !== exp_reg_out() || {awready, wready} !== 2'b11) begin
            errors++; $display("FAIL rst_mid_state: got bvalid=%b reg=%h aw/w ready=%b required 0 0 11",
                               bvalid, reg_out, {awready, wready});
        end
        do_write(32'h10, 32'hA5A5_0F0F, 4'hF, 0, 2, r, p, lat, to);
        model_write(32'h10, 32'hA5A5_0F0F, 4'hF, er, ep);
        checks++;
        if (to || r !== er || p !== ep || lat != 1 || reg_out !== exp_reg_out()) begin
            errors++; $display("FAIL rst_mid_fresh: got to=%0d resp=%b pulse=%h lat=%0d required resp=%b pulse=%h lat=1",
                               to, r, p, lat, er, ep);
        end
    endtask

    task automatic test_random();
        logic [1:0] r, er; logic [NR-1:0] p, ep; logic [DW-1:0] d, ed, dat;
        logic [AW-1:0] addr; logic [3:0] s; int lat; bit to;
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < NR; i++) ro_val[i] = $urandom();
            addr = AW'($urandom_range(0, 19)) * 4 + AW'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                dat = $urandom(); s = 4'($urandom());
                do_write(addr, dat, s, $urandom_range(0, 2), $urandom_range(0, 2), r, p, lat, to);
                model_write(addr, dat, s, er, ep);
                checks++;
                if (to || r !== er || p !== ep || lat != 1 || reg_out !== exp_reg_out()) begin
                    errors++; $display("FAIL rnd_write %0d addr=%h: got to=%0d resp=%b pulse=%h lat=%0d required resp=%b pulse=%h lat=1",
                                       it, addr, to, r, p, lat, er, ep);
                end
            end else begin
                model_read(addr, ed, er, ep);
                do_read(addr, d, r, p, lat, to);
                checks++;
                if (to || d !== ed || r !== er || p !== ep || lat != 0) begin
                    errors++; $display("FAIL rnd_read %0d addr=%h: got to=%0d data=%h resp=%b pulse=%h required data=%h resp=%b pulse=%h",
                                       it, addr, to, d, r, p, ed, er, ep);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_errors();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
